// File: rtl/dr_link_rx_if.sv
// Dual-rail link plus decoded-word output bundle for dr_link_rx.
// The receiver uses the slave modport; the sender/consumer side uses master.
interface dr_link_rx_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int RAIL_NUM = 2;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0][RAIL_NUM-1:0] data;
  logic                           ack;
  logic [WIDTH-1:0]               out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           err;
  logic [CNT_W-1:0]               count;

  modport master (
    output data, out_ready,
    input  ack, out_data, out_valid, err, count
  );

  modport slave (
    input  data, out_ready,
    output ack, out_data, out_valid, err, count
  );
endinterface

// File: rtl/dr_link_rx.sv
// Four-phase dual-rail receiver: synchronises rails, detects completion/spacer,
// drives ack and queues decoded words in a first-word-fall-through FIFO.
module dr_link_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic         clk,
  input  logic         rst,
  dr_link_rx_if.slave  lnk
);
  localparam int RAIL_NUM = 2;
  localparam int AW       = $clog2(DEPTH);
  localparam int CNT_W    = AW + 1;

  typedef enum logic {WAIT_DATA, WAIT_SPACER} state_t;

  logic [WIDTH-1:0][RAIL_NUM-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]               rail1, rail0;
  logic                           complete, spacer, illegal;

  state_t                         state_q, state_d;
  logic                           err_q, err_d;
  logic [WIDTH-1:0]               mem_q [DEPTH];
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           push, pop, full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= lnk.data;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Code 11 is counted as valid and decodes to 1, so rail1 alone is the data.
  always_comb begin
    rail1 = '0;
    rail0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rail1[i] = sync_q[SYNC_STAGES-1][i][1];
      rail0[i] = sync_q[SYNC_STAGES-1][i][0];
    end
  end

  assign complete = &(rail1 | rail0);
  assign spacer   = ~|(rail1 | rail0);
  assign illegal  = |(rail1 & rail0);

  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = (count_q != '0) && lnk.out_ready;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (complete && (!full || pop)) begin
          push    = 1'b1;
          state_d = WAIT_SPACER;
        end
      end
      WAIT_SPACER: begin
        if (spacer) state_d = WAIT_DATA;
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_comb begin
    err_d    = err_q | (push & illegal);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT_DATA;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= rail1;
    end
  end

  assign lnk.ack       = (state_q == WAIT_SPACER);
  assign lnk.out_data  = mem_q[rd_ptr_q];
  assign lnk.out_valid = (count_q != '0);
  assign lnk.err       = err_q;
  assign lnk.count     = count_q;
endmodule

// File: tb/tb_dr_link_rx.sv
// Randomised and directed bench for dr_link_rx with a queue-based scoreboard.
module tb_dr_link_rx;
  localparam int W = 8;
  localparam int D = 2;
  localparam int S = 2;

  typedef logic [W-1:0][1:0] rails_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dr_link_rx_if #(.WIDTH(W), .DEPTH(D)) bus();

  dr_link_rx #(.WIDTH(W), .SYNC_STAGES(S), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .lnk (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [W-1:0] exp_q[$];
  bit          rnd_rdy = 1'b0;

  // Behavioural encoding: unset bits are null, illegal bits are 11.
  function automatic rails_t enc(input logic [W-1:0] v, input logic [W-1:0] ill,
                                 input logic [W-1:0] en);
    rails_t r;
    for (int i = 0; i < W; i++) begin
      if (!en[i])      r[i] = 2'b00;
      else if (ill[i]) r[i] = 2'b11;
      else             r[i] = v[i] ? 2'b10 : 2'b01;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns number of clk edges until ack reaches lvl, or -1 on timeout.
  task automatic wait_ack(input logic lvl, input int maxc, output int n);
    bit done;
    done = 1'b0;
    n    = -1;
    for (int k = 1; k <= maxc && !done; k++) begin
      @(posedge clk); #1;
      if (bus.ack === lvl) begin
        n    = k;
        done = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] v, input logic [W-1:0] ill, output int nup, output int ndn);
    bus.data = enc(v, ill, '1);
    exp_q.push_back(v | ill);
    wait_ack(1'b1, 400, nup);
    bus.data = '0;
    wait_ack(1'b0, 400, ndn);
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && bus.count != 0; k++) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    check({name, "_drained_q"}, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst) begin
      check("count_bound", (bus.count <= D) ? 1 : 0, 1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", bus.out_data, 32'hDEAD);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nup, ndn;
    logic [W-1:0] en, v, ill;

    bus.data      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", bus.ack, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_err", bus.err, 0);
    check("rst_count", bus.count, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Test 1: single word, latency and one-cycle out_valid pulse
    bus.out_ready = 1'b1;
    bus.data = enc(8'hA5, '0, '1);
    exp_q.push_back(8'hA5);
    wait_ack(1'b1, 20, nup);
    check("t1_ack_rise_lat", nup, S + 1);
    check("t1_valid_on_push", bus.out_valid, 1);
    @(posedge clk); #1;
    check("t1_valid_pulse_end", bus.out_valid, 0);
    bus.data = '0;
    wait_ack(1'b0, 20, ndn);
    check("t1_ack_fall_lat", ndn, S + 1);
    check("t1_err", bus.err, 0);
    bus.out_ready = 1'b0;

    // Test 2: full FIFO stalls the handshake; pop and push share an edge
    send(8'h01, '0, nup, ndn);
    check("t2_w1_ack", (nup > 0 && ndn > 0) ? 1 : 0, 1);
    send(8'h02, '0, nup, ndn);
    check("t2_w2_ack", (nup > 0 && ndn > 0) ? 1 : 0, 1);
    check("t2_count_full", bus.count, D);
    bus.data = enc(8'h03, '0, '1);
    exp_q.push_back(8'h03);
    repeat (6) @(posedge clk);
    #1;
    check("t2_ack_held", bus.ack, 0);
    check("t2_count_held", bus.count, D);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("t2_count_same", bus.count, D);
    check("t2_ack_rise", bus.ack, 1);
    bus.data = '0;
    wait_ack(1'b0, 20, ndn);
    check("t2_ack_fall", (ndn > 0) ? 1 : 0, 1);
    drain("t2");

    // Test 3: skewed arrival and skewed spacer, plus early re-validation
    bus.out_ready = 1'b1;
    en = '0;
    exp_q.push_back(8'h5C);
    for (int b = 0; b < W; b++) begin
      en[b] = 1'b1;
      bus.data = enc(8'h5C, '0, en);
      @(posedge clk); #1;
      check("t3_no_early_ack", bus.ack, 0);
    end
    wait_ack(1'b1, 20, nup);
    check("t3_ack_lat", nup + 1, S + 1);
    for (int b = 0; b < W / 2; b++) begin
      en[b] = 1'b0;
      bus.data = enc(8'h5C, '0, en);
      @(posedge clk); #1;
      check("t3_ack_partial_spacer", bus.ack, 1);
    end
    bus.data = enc(8'h5C, '0, '1);
    repeat (5) @(posedge clk);
    #1;
    check("t3_ack_revalid", bus.ack, 1);
    en = '1;
    for (int b = 0; b < W; b++) begin
      en[b] = 1'b0;
      bus.data = enc(8'h5C, '0, en);
      @(posedge clk); #1;
      if (b < W - 1) check("t3_ack_skew_spacer", bus.ack, 1);
    end
    wait_ack(1'b0, 20, ndn);
    check("t3_ack_fall", (ndn >= 0) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t3_single_push_q", exp_q.size(), 0);

    // Test 4: illegal rail code sets sticky err and decodes to 1
    check("t4_err_before", bus.err, 0);
    send(8'h00, 8'h08, nup, ndn);
    check("t4_ack", (nup > 0 && ndn > 0) ? 1 : 0, 1);
    check("t4_err_set", bus.err, 1);
    send(8'h77, '0, nup, ndn);
    check("t4_err_sticky", bus.err, 1);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;

    // Test 5: asynchronous reset mid-handshake, then recapture
    bus.data = enc(8'h3C, '0, '1);
    exp_q.push_back(8'h3C);
    wait_ack(1'b1, 20, nup);
    check("t5_ack_up", (nup > 0) ? 1 : 0, 1);
    check("t5_count_one", bus.count, 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_ack", bus.ack, 0);
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_count", bus.count, 0);
    check("t5_rst_err", bus.err, 0);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(8'h3C);
    rst = 1'b1;
    wait_ack(1'b1, 20, nup);
    check("t5_recapture_lat", nup, S + 1);
    check("t5_recapture_count", bus.count, 1);
    bus.data = '0;
    wait_ack(1'b0, 20, ndn);
    drain("t5");

    // Test 6: random stream with random consumer back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      v   = W'($urandom);
      ill = ($urandom_range(0, 9) == 0) ? W'(1) << $urandom_range(0, W - 1) : '0;
      send(v, ill, nup, ndn);
      check("t6_handshake", (nup > 0 && ndn > 0) ? 1 : 0, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dr_link_rx.md
Name: dr_link_rx

Overview:
- Clocked receiver for the dual-rail, four-phase return-to-zero link that ring-style async sources drive (data[WIDTH-1:0][RAIL_NUM-1:0] + ack).
- Synchronises the rails into the clk domain, detects completion (all bits valid) and spacer (all bits null), decodes to single-rail and drives ack.
- Buffers decoded words in a small FIFO with a valid/ready output.
- Sits at the async-to-sync boundary, in front of synchronous consumers.

Parameters:
WIDTH, 32, data bits per link word
RAIL_NUM, 2, rails per bit (localparam, fixed at 2; rail[1]=logic 1, rail[0]=logic 0)
SYNC_STAGES, 2, synchroniser flops per rail (min 2)
DEPTH, 4, output FIFO entries (power of 2, min 2)

Ports:
clk  in  1  receiver clock
rst  in  1  asynchronous, active-low reset
data  in  [WIDTH-1:0][RAIL_NUM-1:0]  dual-rail link data from sender
ack  out  1  link acknowledge to sender (1 = word consumed, 0 = spacer consumed)
out_data  out  WIDTH  decoded word at FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid && out_ready
err  out  1  sticky: illegal rail code 11 seen on a captured word
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): ack=0, out_valid=0, out_data=0, err=0, count=0; all sync flops 0; FSM to WAIT_DATA. Sender must present spacer during reset.
- Sync: each rail passes through SYNC_STAGES flops; all decisions use synced rails only.
- Bit states: 00 null, 01 = 0, 10 = 1, 11 illegal (counts as valid, decodes to 1).
- complete = every bit non-null; spacer = every bit null; a mix is in-flight.
- FSM WAIT_DATA (ack=0):
  - if complete && count<DEPTH: at next edge push decoded word, set err if any bit is 11, ack<=1, go WAIT_SPACER.
  - if complete && full: hold; no push and ack stays 0 until a pop frees space.
  - Push in the same cycle as a pop from a full FIFO is allowed; the pop frees the slot in that cycle.
- FSM WAIT_SPACER (ack=1):
  - if spacer: at next edge ack<=0, go WAIT_DATA.
  - partial spacer: wait.
  - Rails returning to valid without a full spacer is ignored; no second push.
- Exactly one push per four-phase cycle.
- Latency: input complete at the pins to push edge = SYNC_STAGES+1 clk edges. out_valid rises on the push edge when the FIFO was empty. Spacer at the pins to ack fall = SYNC_STAGES+1 edges.
- FIFO:
  - first-word-fall-through; out_data = mem[rd_ptr].
  - pop on out_valid && out_ready.
  - pointers wrap modulo DEPTH; count tracks push minus pop.
  - simultaneous push and pop leaves count unchanged.
  - out_data holds its value when empty and is not checked.
- err: clears only on reset.
- Reset mid-handshake: ack drops asynchronously and FIFO contents are discarded. After release the FSM waits in WAIT_DATA; a word still asserted on the rails is captured as new.

Test Plan:
1. WIDTH=8, DEPTH=2. Reset, drive word 0xA5 dual-rail, out_ready=1 -> ack rises 3 edges after complete; out_valid pulses one cycle with out_data=0xA5. Drive spacer -> ack falls 3 edges later. err=0.
2. out_ready=0. Send 0x01, 0x02, 0x03 with full handshakes -> first two words acked and count=2. Third word stays complete with ack=0. Assert out_ready for one cycle -> pops 0x01; 0x03 is pushed on that same edge; count stays 2; ack rises.
3. Skewed arrival: assert bit rails one per cycle over 8 cycles -> no push until the last bit is synced; exactly one push of the correct value. Release spacer bits one at a time -> ack stays 1 until all are null.
4. Word with bit3 = 11, others encoding 0x00 -> push 0x08, err=1. err stays 1 across later clean words until reset.
5. Reset asserted while ack=1 and count=1 -> ack, out_valid, count and err are 0 immediately, without waiting for a clk edge. Release with the rails still complete -> word recaptured after 3 edges.
6. Back-to-back random stream of 100 words, random out_ready -> scoreboard in-order match, no loss or duplication, count never exceeds DEPTH.
